conv_input_sequencer: RTL and testbench

- Controller for the 5-entry × 16-bit convolution input register bank.
- Accepts one window of NUM_TAPS samples on a valid/ready input stream and writes them into the bank (write mode).
- Then replays the window to the MAC datapath as a valid/ready output stream (read mode), once per configured pass (one pass per kernel).
- Sits between the input-fetch logic and the convolution MAC. It is the only master of the bank's enable/rw_mode/addr/input_data pins.

---
 rtl/conv_pkg.sv | 23 ++
 rtl/conv_input_sequencer.sv | 141 ++++++++++++++
 tb/tb_conv_input_sequencer.sv | 509 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants for the convolution input path: default geometry of the
// input register bank, sequencer state encoding and bank rw_mode values.
package conv_pkg;

  // Default geometry of the 5-entry x 16-bit input register bank
  localparam int DEF_DATA_W   = 16;
  localparam int DEF_NUM_TAPS = 5;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_PASS_W   = 4;

  // Sequencer state encoding (3-bit, legacy-compatible constants)
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_RD_ISSUE = 3'd2;
  localparam logic [2:0] ST_RD_WAIT  = 3'd3;
  localparam logic [2:0] ST_RD_HOLD  = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  // Bank rw_mode pin values
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/conv_input_sequencer.sv
// Controller for the convolution input register bank. Loads one window of
// NUM_TAPS samples from a valid/ready input stream into the bank, then
// replays it to the MAC once per configured pass on a valid/ready output.
//
// Handshake semantics (both streams): a beat transfers on a rising clk edge
// where valid and ready are both high. in_ready is high only in LOAD and does
// not depend on in_valid. out_valid is high only in RD_HOLD and, once high,
// out_data/out_tap/out_last stay stable until the transfer edge; out_valid
// does not depend on out_ready.
//
// fsm_state exposes the current state encoding for observation.
module conv_input_sequencer
  import conv_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_TAPS = DEF_NUM_TAPS,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int PASS_W   = DEF_PASS_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PASS_W-1:0] cfg_passes,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_tap,
  output logic              out_last,
  input  logic              out_ready,
  output logic              bank_en,
  output logic              bank_rw,
  output logic [ADDR_W-1:0] bank_addr,
  output logic [DATA_W-1:0] bank_wdata,
  input  logic [DATA_W-1:0] bank_rdata,
  output logic              busy,
  output logic              done,
  output logic [2:0]        fsm_state
);

  localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(NUM_TAPS - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] tap;
  logic [PASS_W-1:0] pass;
  logic [PASS_W-1:0] passes;

  // State, counters and the registered replay sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      tap      <= '0;
      pass     <= '0;
      passes   <= '0;
      out_data <= '0;
      out_tap  <= '0;
      out_last <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            // A pass count of zero still replays the window once
            passes <= (cfg_passes == '0) ? PASS_W'(1) : cfg_passes;
            tap    <= '0;
            pass   <= '0;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (tap == LAST_TAP) begin
              tap   <= '0;
              state <= ST_RD_ISSUE;
            end else begin
              tap <= tap + ADDR_W'(1);
            end
          end
        end
        ST_RD_ISSUE: begin
          state <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          // Bank output is valid only during this cycle; capture it here
          out_data <= bank_rdata;
          out_tap  <= tap;
          out_last <= (tap == LAST_TAP);
          state    <= ST_RD_HOLD;
        end
        ST_RD_HOLD: begin
          if (out_ready) begin
            if (!out_last) begin
              tap   <= tap + ADDR_W'(1);
              state <= ST_RD_ISSUE;
            end else if (pass != passes - PASS_W'(1)) begin
              pass  <= pass + PASS_W'(1);
              tap   <= '0;
              state <= ST_RD_ISSUE;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Stream and status outputs decoded from state
  always_comb begin
    in_ready  = (state == ST_LOAD);
    out_valid = (state == ST_RD_HOLD);
    busy      = (state != ST_IDLE);
    done      = (state == ST_DONE);
    fsm_state = state;
  end

  // Bank pins: write on an accepted load beat, read in RD_ISSUE, idle otherwise
  always_comb begin
    bank_en    = 1'b0;
    bank_rw    = RW_WRITE;
    bank_addr  = '0;
    bank_wdata = '0;
    if (state == ST_LOAD && in_valid) begin
      bank_en    = 1'b1;
      bank_rw    = RW_WRITE;
      bank_addr  = tap;
      bank_wdata = in_data;
    end else if (state == ST_RD_ISSUE) begin
      bank_en   = 1'b1;
      bank_rw   = RW_READ;
      bank_addr = tap;
    end
  end

endmodule

// File: tb/tb_conv_input_sequencer.sv
// Bench for conv_input_sequencer together with a behavioural model of the
// 5-entry input register bank (registered read data, one cycle after issue).
module tb_conv_input_sequencer;
  import conv_pkg::*;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int PW = 4;
  localparam int NT = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [PW-1:0] cfg_passes;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [AW-1:0] out_tap;
  logic          out_last;
  logic          out_ready;
  logic          bank_en;
  logic          bank_rw;
  logic [AW-1:0] bank_addr;
  logic [DW-1:0] bank_wdata;
  logic [DW-1:0] bank_rdata;
  logic          busy;
  logic          done;
  logic [2:0]    fsm_state;

  int checks   = 0;
  int failures = 0;

  // clock / reset
  always #5 clk = ~clk;

  conv_input_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .cfg_passes(cfg_passes),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_tap(out_tap),
    .out_last(out_last), .out_ready(out_ready),
    .bank_en(bank_en), .bank_rw(bank_rw), .bank_addr(bank_addr),
    .bank_wdata(bank_wdata), .bank_rdata(bank_rdata),
    .busy(busy), .done(done), .fsm_state(fsm_state)
  );

  // register bank model; the floating read bus is modelled as zero
  logic [DW-1:0] mem [8];
  logic [DW-1:0] rd_q = '0;
  logic          rd_v = 1'b0;
  always @(posedge clk) begin
    rd_v <= 1'b0;
    if (bank_en && bank_rw == RW_WRITE) mem[bank_addr] <= bank_wdata;
    if (bank_en && bank_rw == RW_READ) begin
      rd_q <= mem[bank_addr];
      rd_v <= 1'b1;
    end
  end
  assign bank_rdata = rd_v ? rd_q : '0;

  // scoreboard state
  logic [DW+AW:0]   exp_q[$];
  logic [DW+AW:0]   out_log[$];
  logic [DW+AW-1:0] exp_w[$];
  logic [DW+AW-1:0] wr_log[$];
  int done_cnt;
  int en_bad;

  // monitor: log bank writes, output transfers, done pulses, stray enables
  always @(negedge clk) begin
    if (!rst) begin
      if (bank_en && bank_rw == RW_WRITE) wr_log.push_back({bank_addr, bank_wdata});
      if (out_valid && out_ready) out_log.push_back({out_last, out_tap, out_data});
      if (done) done_cnt++;
      if (bank_en && ((fsm_state inside {ST_IDLE, ST_RD_WAIT, ST_RD_HOLD, ST_DONE}) ||
                      (fsm_state == ST_LOAD && !in_valid))) en_bad++;
    end
  end

  // driver tasks
  task automatic clear_logs();
    out_log.delete();
    wr_log.delete();
    done_cnt = 0;
    en_bad   = 0;
  endtask

  task automatic build_exp(input logic [DW-1:0] base, input logic [DW-1:0] step, input int passes);
    exp_q.delete();
    exp_w.delete();
    for (int p = 0; p < passes; p++)
      for (int t = 0; t < NT; t++)
        exp_q.push_back({(t == NT - 1), AW'(t), DW'(base + step * DW'(t))});
    for (int t = 0; t < NT; t++)
      exp_w.push_back({AW'(t), DW'(base + step * DW'(t))});
  endtask

  task automatic pulse_start(input logic [PW-1:0] p);
    @(posedge clk); #1;
    start = 1'b1;
    cfg_passes = p;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_passes = 4'hF;
  endtask

  // Returns at 1 time unit after the final load handshake edge
  task automatic load_window(input logic [DW-1:0] base, input logic [DW-1:0] step,
                             input int gap, input int start_at);
    int w;
    for (int i = 0; i < NT; i++) begin
      if (i == start_at) begin
        start = 1'b1;
        cfg_passes = 4'd7;
        @(posedge clk); #1;
        start = 1'b0;
        cfg_passes = 4'hF;
      end
      in_valid = 1'b1;
      in_data  = base + step * DW'(i);
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) begin
        checks++;
        failures++;
        $display("FAIL load_ready beat=%0d in_ready=%0b required=1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 16'hBEEF;
      if (i < NT - 1) repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_done(input int budget, output int cycles, output int first_v);
    cycles  = 0;
    first_v = -1;
    do begin
      @(negedge clk);
      cycles++;
      if (out_valid && first_v < 0) first_v = cycles;
    end while (!done && cycles < budget);
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    cfg_passes = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_tap, out_last, in_ready, bank_en, bank_rw, bank_addr,
         bank_wdata, busy, done} !== 45'd0 || fsm_state !== ST_IDLE) begin
      failures++;
      $display("FAIL reset_outputs valid=%0b data=%h tap=%0d last=%0b in_ready=%0b en=%0b busy=%0b done=%0b state=%0d required all zero",
               out_valid, out_data, out_tap, out_last, in_ready, bank_en, busy, done, fsm_state);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    clear_logs();
    in_valid = 1'b1;
    in_data  = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0 || bank_en !== 1'b0 || fsm_state !== ST_IDLE) begin
        failures++;
        $display("FAIL idle_in_valid in_ready=%0b en=%0b state=%0d required 0/0/0", in_ready, bank_en, fsm_state);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (wr_log.size() != 0) begin
      failures++;
      $display("FAIL idle_writes got=%0d required=0", wr_log.size());
    end
  endtask

  task automatic test_basic();
    int cyc, fv;
    clear_logs();
    build_exp(16'h0011, 16'h0011, 1);
    out_ready = 1'b1;
    pulse_start(4'd1);
    load_window(16'h0011, 16'h0011, 0, -1);
    wait_done(60, cyc, fv);
    checks++;
    if (cyc != 16 || done !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency got=%0d required=16", cyc);
    end
    checks++;
    if (fv != 3) begin
      failures++;
      $display("FAIL basic_first_valid got=%0d required=3", fv);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || done_cnt != 1) begin
      failures++;
      $display("FAIL basic_end busy=%0b done=%0b done_cnt=%0d required 0/0/1", busy, done, done_cnt);
    end
    checks++;
    if (wr_log.size() != NT) begin
      failures++;
      $display("FAIL basic_writes got=%0d required=%0d", wr_log.size(), NT);
    end else begin
      for (int i = 0; i < NT; i++) begin
        checks++;
        if (wr_log[i] !== exp_w[i]) begin
          failures++;
          $display("FAIL basic_write[%0d] got=%h required=%h", i, wr_log[i], exp_w[i]);
        end
      end
    end
    checks++;
    if (out_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL basic_beats got=%0d required=%0d", out_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (out_log[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL basic_beat[%0d] got=%h required=%h", i, out_log[i], exp_q[i]);
        end
      end
    end
    checks++;
    if (en_bad != 0) begin
      failures++;
      $display("FAIL basic_stray_en got=%0d required=0", en_bad);
    end
  endtask

  task automatic test_multi_pass();
    int cyc, fv;
    clear_logs();
    build_exp(16'hA000, 16'h0001, 3);
    out_ready = 1'b1;
    pulse_start(4'd3);
    load_window(16'hA000, 16'h0001, 0, -1);
    wait_done(100, cyc, fv);
    checks++;
    if (cyc != 46 || done !== 1'b1) begin
      failures++;
      $display("FAIL multi_latency got=%0d required=46", cyc);
    end
    @(negedge clk); #1;
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL multi_done done_cnt=%0d busy=%0b required 1/0", done_cnt, busy);
    end
    checks++;
    if (out_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL multi_beats got=%0d required=%0d", out_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (out_log[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL multi_beat[%0d] got=%h required=%h", i, out_log[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int w, cyc, fv;
    clear_logs();
    build_exp(16'h0011, 16'h0011, 1);
    out_ready = 1'b0;
    pulse_start(4'd1);
    load_window(16'h0011, 16'h0011, 0, -1);
    for (int b = 0; b < NT; b++) begin
      w = 0;
      @(negedge clk);
      while (!out_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      checks++;
      if (out_valid !== 1'b1 || out_tap !== AW'(b)) begin
        failures++;
        $display("FAIL bp_valid beat=%0d valid=%0b tap=%0d required 1/%0d", b, out_valid, out_tap, b);
      end
      if (b == 2) begin
        for (int s = 0; s < 4; s++) begin
          @(negedge clk);
          checks++;
          if (out_valid !== 1'b1 || out_data !== 16'h0033 || out_tap !== 3'd2 ||
              out_last !== 1'b0 || bank_en !== 1'b0) begin
            failures++;
            $display("FAIL bp_stall cyc=%0d valid=%0b data=%h tap=%0d en=%0b required 1/0033/2/0",
                     s, out_valid, out_data, out_tap, bank_en);
          end
        end
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      if (b < NT - 1) begin
        @(negedge clk);
        checks++;
        if (bank_en !== 1'b1 || bank_rw !== RW_READ || bank_addr !== AW'(b + 1)) begin
          failures++;
          $display("FAIL bp_next_issue beat=%0d en=%0b rw=%0b addr=%0d required 1/1/%0d",
                   b, bank_en, bank_rw, bank_addr, b + 1);
        end
      end
    end
    wait_done(10, cyc, fv);
    checks++;
    if (cyc != 1 || done !== 1'b1) begin
      failures++;
      $display("FAIL bp_done got=%0d required=1", cyc);
    end
    out_ready = 1'b1;
    checks++;
    if (out_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL bp_beats got=%0d required=%0d", out_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (out_log[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL bp_beat[%0d] got=%h required=%h", i, out_log[i], exp_q[i]);
        end
      end
    end
    @(negedge clk); #1;
    checks++;
    if (en_bad != 0) begin
      failures++;
      $display("FAIL bp_stray_en got=%0d required=0", en_bad);
    end
  endtask

  task automatic test_gaps_zero_passes();
    int cyc, fv;
    clear_logs();
    build_exp(16'h0500, 16'h0003, 1);
    out_ready = 1'b1;
    pulse_start(4'd0);
    load_window(16'h0500, 16'h0003, 2, -1);
    wait_done(60, cyc, fv);
    checks++;
    if (cyc != 16 || done !== 1'b1) begin
      failures++;
      $display("FAIL gaps_latency got=%0d required=16", cyc);
    end
    @(negedge clk); #1;
    checks++;
    if (done_cnt != 1 || en_bad != 0) begin
      failures++;
      $display("FAIL gaps_done done_cnt=%0d stray_en=%0d required 1/0", done_cnt, en_bad);
    end
    checks++;
    if (wr_log.size() != NT) begin
      failures++;
      $display("FAIL gaps_writes got=%0d required=%0d", wr_log.size(), NT);
    end else begin
      for (int i = 0; i < NT; i++) begin
        checks++;
        if (wr_log[i] !== exp_w[i]) begin
          failures++;
          $display("FAIL gaps_write[%0d] got=%h required=%h", i, wr_log[i], exp_w[i]);
        end
      end
    end
    checks++;
    if (out_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL gaps_beats got=%0d required=%0d", out_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (out_log[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL gaps_beat[%0d] got=%h required=%h", i, out_log[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int cyc, fv;
    clear_logs();
    build_exp(16'h0C10, 16'h0101, 2);
    out_ready = 1'b1;
    pulse_start(4'd2);
    load_window(16'h0C10, 16'h0101, 0, 2);
    wait_done(100, cyc, fv);
    checks++;
    if (cyc != 31 || done !== 1'b1) begin
      failures++;
      $display("FAIL swb_latency got=%0d required=31", cyc);
    end
    @(negedge clk); #1;
    checks++;
    if (done_cnt != 1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL swb_done done_cnt=%0d busy=%0b required 1/0", done_cnt, busy);
    end
    checks++;
    if (out_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL swb_beats got=%0d required=%0d", out_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (out_log[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL swb_beat[%0d] got=%h required=%h", i, out_log[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_replay();
    int w, cyc, fv;
    clear_logs();
    out_ready = 1'b1;
    pulse_start(4'd2);
    load_window(16'h0700, 16'h0001, 0, -1);
    w = 0;
    @(negedge clk); #1;
    while (!(out_valid && out_log.size() >= 6) && w < 60) begin
      @(negedge clk); #1;
      w++;
    end
    checks++;
    if (fsm_state !== ST_RD_HOLD || out_log.size() < 6) begin
      failures++;
      $display("FAIL rst_mid_reach state=%0d beats=%0d required %0d/>=6", fsm_state, out_log.size(), ST_RD_HOLD);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, out_data, out_tap, out_last, in_ready, bank_en, bank_rw, bank_addr,
         bank_wdata, busy, done} !== 45'd0 || fsm_state !== ST_IDLE) begin
      failures++;
      $display("FAIL rst_mid_outputs valid=%0b data=%h tap=%0d last=%0b busy=%0b state=%0d required all zero",
               out_valid, out_data, out_tap, out_last, busy, fsm_state);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    build_exp(16'h0100, 16'h0001, 1);
    pulse_start(4'd1);
    load_window(16'h0100, 16'h0001, 0, -1);
    wait_done(60, cyc, fv);
    checks++;
    if (cyc != 16 || done !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_latency got=%0d required=16", cyc);
    end
    @(negedge clk); #1;
    checks++;
    if (out_log.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rst_mid_beats got=%0d required=%0d", out_log.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (out_log[i] !== exp_q[i]) begin
          failures++;
          $display("FAIL rst_mid_beat[%0d] got=%h required=%h", i, out_log[i], exp_q[i]);
        end
      end
    end
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // sequence and final report
  initial begin
    test_reset();
    test_basic();
    test_multi_pass();
    test_backpressure();
    test_gaps_zero_passes();
    test_start_while_busy();
    test_reset_mid_replay();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
